// File: rtl/touch_led_array.sv
// Multi-channel touch-key front end: synchroniser, debounce, press-edge detect and LED drive per channel.
// Optional long-press clear is built only when TOUCH_LONG_PRESS_EN is defined.
module touch_led_array #(
   parameter int   CH_NUM    = 4,
   parameter int   DEB_CNT   = 999_999,
   parameter logic TOUCH_ACT = 1'b0,
   parameter int   MODE      = 0,
   parameter int   LONG_CNT  = 49_999_999
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [CH_NUM-1:0] touch_in,
   output logic [CH_NUM-1:0] led_out,
   output logic [CH_NUM-1:0] press_pulse,
   output logic [CH_NUM-1:0] key_state,
   output logic              long_pulse
);

   localparam int              DW       = $clog2(DEB_CNT + 1);
   localparam logic [DW-1:0]   DEB_MAX  = DW'(DEB_CNT);
   localparam logic [DW-1:0]   DEB_ONE  = DW'(1);
   localparam logic [CH_NUM-1:0] IDLE_LVL = {CH_NUM{~TOUCH_ACT}};

   if ((CH_NUM < 1) || (CH_NUM > 16) || (DEB_CNT < 1) || (LONG_CNT < 1)) begin : g_param_err
      $error("touch_led_array: parameter out of range");
   end

   logic [CH_NUM-1:0] sync1_r;
   logic [CH_NUM-1:0] sync2_r;
   logic [CH_NUM-1:0] pressed_s;
   logic [CH_NUM-1:0] key_state_r;
   logic [CH_NUM-1:0] key_nxt_s;
   logic [CH_NUM-1:0] key_dly_r;
   logic [CH_NUM-1:0] rise_s;
   logic [CH_NUM-1:0] press_pulse_r;
   logic [CH_NUM-1:0] led_r;
   logic [CH_NUM-1:0] led_nxt_s;
   logic              long_pulse_r;
   logic              any_long_s;
   logic [DW-1:0]     deb_cnt_r     [CH_NUM];
   logic [DW-1:0]     deb_cnt_nxt_s [CH_NUM];

   // Two-stage synchroniser; reset loads the released pad level so a held key must requalify
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync1_r <= IDLE_LVL;
         sync2_r <= IDLE_LVL;
      end else begin
         sync1_r <= touch_in;
         sync2_r <= sync1_r;
      end
   end

   assign pressed_s = sync2_r ^ IDLE_LVL;

   // Debounce: count consecutive disagreeing samples, flip once DEB_CNT is reached, clear on agreement
   always_comb begin
      key_nxt_s = key_state_r;
      for (int i = 0; i < CH_NUM; i++) begin
         deb_cnt_nxt_s[i] = deb_cnt_r[i];
         if (pressed_s[i] != key_state_r[i]) begin
            if (deb_cnt_r[i] == DEB_MAX) begin
               key_nxt_s[i]     = ~key_state_r[i];
               deb_cnt_nxt_s[i] = '0;
            end else begin
               deb_cnt_nxt_s[i] = deb_cnt_r[i] + DEB_ONE;
            end
         end else begin
            deb_cnt_nxt_s[i] = '0;
         end
      end
   end

   assign rise_s = key_state_r & ~key_dly_r;

`ifdef TOUCH_LONG_PRESS_EN
   localparam int            LW       = $clog2(LONG_CNT + 1);
   localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CNT);
   localparam logic [LW-1:0] LONG_ARM = LW'(LONG_CNT - 1);
   localparam logic [LW-1:0] LONG_ONE = LW'(1);

   logic [LW-1:0]     hold_cnt_r [CH_NUM];
   logic [CH_NUM-1:0] long_hit_s;

   // Hold counters run while the key is down, saturate at LONG_CNT and clear on release
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         for (int i = 0; i < CH_NUM; i++) begin
            hold_cnt_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CH_NUM; i++) begin
            if (!key_state_r[i]) begin
               hold_cnt_r[i] <= '0;
            end else if (hold_cnt_r[i] != LONG_MAX) begin
               hold_cnt_r[i] <= hold_cnt_r[i] + LONG_ONE;
            end else begin
               hold_cnt_r[i] <= hold_cnt_r[i];
            end
         end
      end
   end

   // A channel fires on the edge its counter lands on LONG_CNT; saturation makes it once per hold
   always_comb begin
      long_hit_s = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (key_state_r[i] && (hold_cnt_r[i] == LONG_ARM)) begin
            long_hit_s[i] = 1'b1;
         end else begin
            long_hit_s[i] = 1'b0;
         end
      end
   end

   assign any_long_s = |long_hit_s;
`else
   assign any_long_s = 1'b0;
`endif

   // LED next state: toggle on press or follow the key; a long press clears every LED and wins
   always_comb begin
      led_nxt_s = led_r;
      if (any_long_s) begin
         led_nxt_s = '0;
      end else if (MODE == 0) begin
         led_nxt_s = led_r ^ rise_s;
      end else begin
         led_nxt_s = key_state_r;
      end
   end

   // Channel state and output registers
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         key_state_r   <= '0;
         key_dly_r     <= '0;
         press_pulse_r <= '0;
         led_r         <= '0;
         long_pulse_r  <= 1'b0;
         for (int i = 0; i < CH_NUM; i++) begin
            deb_cnt_r[i] <= '0;
         end
      end else begin
         key_state_r   <= key_nxt_s;
         key_dly_r     <= key_state_r;
         press_pulse_r <= rise_s;
         led_r         <= led_nxt_s;
         long_pulse_r  <= any_long_s;
         for (int i = 0; i < CH_NUM; i++) begin
            deb_cnt_r[i] <= deb_cnt_nxt_s[i];
         end
      end
   end

   assign led_out     = led_r;
   assign press_pulse = press_pulse_r;
   assign key_state   = key_state_r;
   assign long_pulse  = long_pulse_r;

endmodule

// File: tb/tb_touch_led_array.sv
// Self-checking bench for touch_led_array: table-driven presses plus hand-written corner sequences,
// with cycle-stamped expectations held in a scoreboard queue. dut0 runs MODE 0, dut1 runs MODE 1.
module tb_touch_led_array;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] touch0, touch1;
   logic [3:0] led0, pp0, ks0, led1, pp1, ks1;
   logic       lp0, lp1;
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;

`ifdef TOUCH_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   touch_led_array #(.CH_NUM(4), .DEB_CNT(4), .TOUCH_ACT(1'b0), .MODE(0), .LONG_CNT(20)) dut0 (
      .sys_clk(clk), .sys_rst(rst), .touch_in(touch0),
      .led_out(led0), .press_pulse(pp0), .key_state(ks0), .long_pulse(lp0));

   touch_led_array #(.CH_NUM(4), .DEB_CNT(4), .TOUCH_ACT(1'b0), .MODE(1), .LONG_CNT(200)) dut1 (
      .sys_clk(clk), .sys_rst(rst), .touch_in(touch1),
      .led_out(led1), .press_pulse(pp1), .key_state(ks1), .long_pulse(lp1));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      bit         dut;
      logic [3:0] led;
      logic [3:0] pulse;
      logic [3:0] ks;
      logic       lp;
      string      name;
   } exp_t;

   typedef struct {
      string      name;
      logic [3:0] mask;
      int         hold;
      bit         pulses;
      logic [3:0] led_before;
      logic [3:0] led_after;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[5];

   task automatic push(input int c, input bit d, input logic [3:0] led, input logic [3:0] pulse,
                       input logic [3:0] ks, input logic lp, input string nm);
      exp_t e;
      e.cyc = c; e.dut = d; e.led = led; e.pulse = pulse; e.ks = ks; e.lp = lp; e.name = nm;
      sb_q.push_back(e);
   endtask

   task automatic check(input exp_t e);
      logic [3:0] a_led, a_pp, a_ks;
      logic       a_lp;
      a_led = e.dut ? led1 : led0;
      a_pp  = e.dut ? pp1  : pp0;
      a_ks  = e.dut ? ks1  : ks0;
      a_lp  = e.dut ? lp1  : lp0;
      n_tests++;
      if (a_led !== e.led || a_pp !== e.pulse || a_ks !== e.ks || a_lp !== e.lp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d dut%0d got led=%h pulse=%h ks=%h lp=%b, want led=%h pulse=%h ks=%h lp=%b",
                  e.name, e.cyc, e.dut, a_led, a_pp, a_ks, a_lp, e.led, e.pulse, e.ks, e.lp);
      end
   endtask

   // Scoreboard: compare every expectation stamped for the cycle just completed
   always @(negedge clk) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].cyc == cyc) begin
            check(sb_q[i]);
            sb_q.delete(i);
         end else if (sb_q[i].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s stale expectation for cyc=%0d at cyc=%0d", sb_q[i].name, sb_q[i].cyc, cyc);
            sb_q.delete(i);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      vecs[0] = '{"press_ch0",   4'h1, 10, 1'b1, 4'h0, 4'h1};
      vecs[1] = '{"repress_ch0", 4'h1, 10, 1'b1, 4'h1, 4'h0};
      vecs[2] = '{"press_ch1",   4'h2, 10, 1'b1, 4'h0, 4'h2};
      vecs[3] = '{"simul_ch23",  4'hC, 10, 1'b1, 4'h2, 4'hE};
      vecs[4] = '{"glitch_ch0",  4'h1,  3, 1'b0, 4'hE, 4'hE};

      // Reset with pads idle high
      rst = 1'b1; touch0 = 4'hF; touch1 = 4'hF;
      for (int c = 1; c <= 5; c++) begin
         push(c, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, "reset");
         push(c, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, "reset_m1");
      end
      repeat (3) tick();
      rst = 1'b0;
      repeat (5) tick();

      // Table-driven presses on dut0
      foreach (vecs[v]) begin
         n = cyc + 1;
         if (vecs[v].pulses) begin
            push(n + 5, 1'b0, vecs[v].led_before, 4'h0, 4'h0, 1'b0, vecs[v].name);
            push(n + 6, 1'b0, vecs[v].led_before, 4'h0, vecs[v].mask, 1'b0, vecs[v].name);
            push(n + 7, 1'b0, vecs[v].led_after, vecs[v].mask, vecs[v].mask, 1'b0, vecs[v].name);
            push(n + 8, 1'b0, vecs[v].led_after, 4'h0, vecs[v].mask, 1'b0, vecs[v].name);
            push(n + vecs[v].hold + 5, 1'b0, vecs[v].led_after, 4'h0, vecs[v].mask, 1'b0, vecs[v].name);
            push(n + vecs[v].hold + 6, 1'b0, vecs[v].led_after, 4'h0, 4'h0, 1'b0, vecs[v].name);
            push(n + vecs[v].hold + 7, 1'b0, vecs[v].led_after, 4'h0, 4'h0, 1'b0, vecs[v].name);
         end else begin
            for (int c = n + 1; c <= n + vecs[v].hold + 8; c++)
               push(c, 1'b0, vecs[v].led_before, 4'h0, 4'h0, 1'b0, vecs[v].name);
         end
         touch0 = ~vecs[v].mask;
         repeat (vecs[v].hold) tick();
         touch0 = 4'hF;
         while (cyc < n + 24) tick();
      end

      // Bounce on ch1: 3 low, 1 high, five times; never qualifies
      n = cyc + 1;
      for (int c = n + 1; c <= n + 26; c++) push(c, 1'b0, 4'hE, 4'h0, 4'h0, 1'b0, "bounce");
      for (int r = 0; r < 5; r++) begin
         touch0 = 4'hD;
         repeat (3) tick();
         touch0 = 4'hF;
         tick();
      end
      while (cyc < n + 28) tick();

      // MODE 1 on dut1: ch0 held 30 cycles
      n = cyc + 1;
      for (int c = n + 5; c <= n + 39; c++)
         push(c, 1'b1, (c >= n + 7 && c < n + 37) ? 4'h1 : 4'h0, (c == n + 7) ? 4'h1 : 4'h0,
              (c >= n + 6 && c < n + 36) ? 4'h1 : 4'h0, 1'b0, "mode1_hold");
      touch1 = 4'hE;
      repeat (30) tick();
      touch1 = 4'hF;
      while (cyc < n + 42) tick();

      // Reset at N+3 during debounce of ch0; the held key requalifies from scratch
      n = cyc + 1;
      push(n + 3,  1'b0, 4'h0, 4'h0, 4'h0, 1'b0, "rst_mid");
      push(n + 3,  1'b1, 4'h0, 4'h0, 4'h0, 1'b0, "rst_mid_m1");
      push(n + 4,  1'b0, 4'h0, 4'h0, 4'h0, 1'b0, "rst_mid");
      push(n + 7,  1'b0, 4'h0, 4'h0, 4'h0, 1'b0, "rst_no_pulse");
      push(n + 8,  1'b0, 4'h0, 4'h0, 4'h0, 1'b0, "rst_no_pulse");
      push(n + 10, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, "rst_requal");
      push(n + 11, 1'b0, 4'h0, 4'h0, 4'h1, 1'b0, "rst_requal");
      push(n + 12, 1'b0, 4'h1, 4'h1, 4'h1, 1'b0, "rst_requal");
      push(n + 13, 1'b0, 4'h1, 4'h0, 4'h1, 1'b0, "rst_requal");
      push(n + 21, 1'b0, 4'h1, 4'h0, 4'h1, 1'b0, "rst_release");
      push(n + 22, 1'b0, 4'h1, 4'h0, 4'h0, 1'b0, "rst_release");
      touch0 = 4'hE;
      repeat (3) tick();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      while (cyc < n + 15) tick();
      touch0 = 4'hF;
      while (cyc < n + 28) tick();

      // Long hold of ch3 for 40 cycles; with the long-press option every LED clears once
      n = cyc + 1;
      push(n + 7, 1'b0, 4'h9, 4'h8, 4'h8, 1'b0, "long_press");
      for (int c = n + 8; c <= n + 50; c++)
         push(c, 1'b0, (LONG_EN && c >= n + 26) ? 4'h0 : 4'h9, 4'h0,
              (c < n + 46) ? 4'h8 : 4'h0, LONG_EN && (c == n + 26), "long_hold");
      touch0 = 4'h7;
      repeat (40) tick();
      touch0 = 4'hF;
      while (cyc < n + 55) tick();

      for (int k = 0; k < 10 && sb_q.size() > 0; k++) tick();
      while (sb_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s never checked (cyc=%0d)", sb_q[0].name, sb_q[0].cyc);
         sb_q.delete(0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
